// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / redirect flush controller for IF/ID and ID/EX (ports: clock, reset(n), hazard inputs, redirect -> pc_write, ifid_write, ifid_flush, idex_bubble, state_out, stall_count, flush_count; optional HAZARD_PERF_EN perf counters)
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rs,
  input  logic             ifid_uses_rt,
  input  logic             redirect,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  logic [1:0] state;
  logic [3:0] fcnt;
  logic hz, flushing, stall;
  assign hz = idex_MemRead && (idex_rd != '0) &&
              ((ifid_uses_rs && ifid_rs == idex_rd) || (ifid_uses_rt && ifid_rt == idex_rd));
  assign flushing = redirect || (state == FLUSH);
  assign stall = !flushing && hz;
  assign pc_write = reset && !stall;
  assign ifid_write = reset && !stall;
  assign ifid_flush = !reset || flushing;
  assign idex_bubble = !reset || flushing || stall;
  assign state_out = state;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      fcnt <= '0;
    end else if (redirect) begin
      state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      fcnt <= (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
    end else if (state == FLUSH) begin
      state <= (fcnt == 4'd1) ? RUN : FLUSH;
      fcnt <= fcnt - 4'd1;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (redirect && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test of hazard_ctrl against a flush-countdown reference model
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int RW = 6;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clock = 0, reset = 0;
  logic idex_MemRead = 0, ifid_uses_rs = 0, ifid_uses_rt = 0, redirect = 0;
  logic [RW-1:0] idex_rd = 0, ifid_rs = 0, ifid_rt = 0;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] state_out;
  logic [CW-1:0] stall_count, flush_count;
  int total = 0, bad = 0;
  int rem = 0, m_st = 0, m_fl = 0;
  hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(RW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .idex_MemRead(idex_MemRead), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .redirect(redirect), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .state_out(state_out), .stall_count(stall_count), .flush_count(flush_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_hz();
    return idex_MemRead && idex_rd != 0 &&
           ((ifid_uses_rs && ifid_rs == idex_rd) || (ifid_uses_rt && ifid_rt == idex_rd));
  endfunction
  // rem = flush cycles still owed after the current one; 0 means running normally
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem <= 0;
      m_st <= 0;
      m_fl <= 0;
    end else if (redirect) begin
      rem <= FC - 1;
      if (m_fl < MAXC) m_fl <= m_fl + 1;
    end else if (rem > 0) rem <= rem - 1;
    else if (m_hz() && m_st < MAXC) m_st <= m_st + 1;
  end
  always @(negedge clock) begin
    bit fl, st;
    fl = redirect || rem > 0;
    st = !fl && m_hz();
    chk("pc_write", {31'b0, pc_write}, {31'b0, reset && !st});
    chk("ifid_write", {31'b0, ifid_write}, {31'b0, reset && !st});
    chk("ifid_flush", {31'b0, ifid_flush}, {31'b0, !reset || fl});
    chk("idex_bubble", {31'b0, idex_bubble}, {31'b0, !reset || fl || st});
    chk("state_out", {30'b0, state_out}, (reset && rem > 0) ? 1 : 0);
`ifdef HAZARD_PERF_EN
    chk("stall_count", {28'b0, stall_count}, m_st);
    chk("flush_count", {28'b0, flush_count}, m_fl);
`else
    chk("stall_count", {28'b0, stall_count}, 0);
    chk("flush_count", {28'b0, flush_count}, 0);
`endif
  end
  task automatic step(input logic mr, input int rd, input int rs, input int rt,
                      input logic urs, input logic urt, input logic rdr);
    @(posedge clock);
    #1;
    idex_MemRead = mr; idex_rd = RW'(rd); ifid_rs = RW'(rs); ifid_rt = RW'(rt);
    ifid_uses_rs = urs; ifid_uses_rt = urt; redirect = rdr;
    #1;
  endtask
  task automatic lit4(input string tag, input logic p, input logic w, input logic f, input logic b);
    chk({tag, "_pc"}, {31'b0, pc_write}, {31'b0, p});
    chk({tag, "_wr"}, {31'b0, ifid_write}, {31'b0, w});
    chk({tag, "_fl"}, {31'b0, ifid_flush}, {31'b0, f});
    chk({tag, "_bb"}, {31'b0, idex_bubble}, {31'b0, b});
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #2;
    lit4("rst", 0, 0, 1, 1);
    chk("rst_state", {30'b0, state_out}, 0);
    @(posedge clock); #1 reset = 1; #1;
    lit4("run", 1, 1, 0, 0);
    step(1, 5, 5, 0, 1, 0, 0);
    lit4("lu", 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    lit4("lu_after", 1, 1, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("lu_cnt", {28'b0, stall_count}, 1);
`endif
    step(1, 0, 0, 0, 1, 1, 0);
    lit4("r0", 1, 1, 0, 0);
    step(1, 7, 1, 7, 1, 0, 0);
    lit4("nouse_rt", 1, 1, 0, 0);
    step(1, 7, 1, 7, 0, 1, 0);
    lit4("use_rt", 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    lit4("rd1", 1, 1, 1, 1);
    chk("rd1_state", {30'b0, state_out}, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    lit4("rd2", 1, 1, 1, 1);
    chk("rd2_state", {30'b0, state_out}, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    lit4("rd3", 1, 1, 0, 0);
    chk("rd3_state", {30'b0, state_out}, 0);
`ifdef HAZARD_PERF_EN
    chk("rd_cnt", {28'b0, flush_count}, 1);
`endif
    step(1, 5, 5, 0, 1, 0, 1);
    lit4("coll", 1, 1, 1, 1);
    step(1, 5, 5, 0, 1, 0, 0);
    lit4("coll_fl_hz", 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("coll_stall_cnt", {28'b0, stall_count}, 2);
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rr_state", {30'b0, state_out}, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    lit4("rr_ext", 1, 1, 1, 1);
    chk("rr_ext_state", {30'b0, state_out}, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rr_end_state", {30'b0, state_out}, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    repeat (20) step(1, 3, 3, 3, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("sat_flush", {28'b0, flush_count}, MAXC);
    chk("sat_stall", {28'b0, stall_count}, MAXC);
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pre_ar_state", {30'b0, state_out}, 1);
    #1 reset = 0;
    #1;
    lit4("ar", 0, 0, 1, 1);
    chk("ar_state", {30'b0, state_out}, 0);
    chk("ar_stall_cnt", {28'b0, stall_count}, 0);
    chk("ar_flush_cnt", {28'b0, flush_count}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    step(1, 9, 2, 9, 0, 1, 0);
    lit4("post_ar", 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
